ram_burst_reader: RTL and testbench
===================================

Name: ram_burst_reader

Overview:
- Downstream stage of the dual-port RAM: drives the RAM read port and turns a burst request into a valid/ready output stream.
- The RAM read port is a registered read with a fixed 1-cycle latency: the address is sampled at clock edge N and the data is valid after edge N+1.
- A 2-entry output buffer absorbs that latency, giving full throughput of 1 beat/cycle under continuous out_ready.
- The RAM's clk_read is driven from this block's clk.

Parameters:
- D_WIDTH, 16, data word width; matches the RAM.
- A_WIDTH, 5, RAM address width; depth = 2**A_WIDTH.

Ports:
- clk  input  1  single clock; also drives RAM clk_read.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  burst request; accepted only when busy=0.
- start_addr  input  A_WIDTH  first read address of the burst.
- length  input  A_WIDTH+1  beat count, 1..2**A_WIDTH.
- address_read  output  A_WIDTH  to RAM read address.
- data_read  input  D_WIDTH  from RAM; valid 1 cycle after address_read is sampled.
- out_data  output  D_WIDTH  stream data.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready.
- out_last  output  1  asserted with the final beat of the burst.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (async assert, sync deassert handled externally) forces these values: state=IDLE, address_read=0, out_valid=0, out_last=0, busy=0, done=0, buffer empty, pending=0, remaining count=0.
- States: IDLE, READ, DRAIN.
- IDLE:
  - start=1 with length!=0 → latch start_addr into the address counter and length into the issue counter and beat counter; go to READ; busy=1 from the next cycle.
  - start=1 with length=0 is ignored: no busy, no done.
- READ:
  - Issue condition: buf_count + pending − pop < 2, where pop = out_valid & out_ready.
  - On issue: present the address counter on address_read, set pending=1 for the next cycle, increment the address, decrement the issue counter.
  - The address wraps modulo 2**A_WIDTH (31 → 0 for the default width).
  - address_read holds its value when not issuing.
  - When the issue counter reaches 0 → DRAIN.
- Capture: in the cycle after an issue (pending=1), push data_read into the buffer. The RAM's data_read is ignored in all other cycles.
- Buffer:
  - 2-entry FIFO; out_data/out_valid come from the head entry.
  - Simultaneous push and pop is allowed at any occupancy.
  - The credit rule makes overflow impossible; any overflow is a design error.
- AXI-style stream rules:
  - Once out_valid=1, it and out_data stay stable until out_ready=1.
  - out_valid never depends combinationally on out_ready.
- out_last=1 exactly while the head entry is the final beat (beat counter == 1).
- DRAIN: when the final beat pops → go to IDLE; busy=0 and done=1 in the next cycle.
- start is ignored while busy=1.
- Latency:
  - start sampled at edge E.
  - First address_read presented after E+1.
  - out_valid first asserts after E+3.
  - Under out_ready=1, an L-beat burst completes at E+L+2, with done high after E+L+3.
- Back-to-back bursts: start may be accepted in the same cycle done is high.
- Asynchronous reset mid-burst: returns to IDLE immediately, flushes the buffer, drops out_valid, and produces no done.
- Writes to the RAM during a burst are not tracked. Read-during-write data follows the RAM's behaviour.

Optional Feature:
- Macro: RAM_BURST_READER_STALL_CNT_EN.
- When defined:
  - Adds output port stall_count, 16 bits.
  - Counts cycles with out_valid=1 and out_ready=0.
  - Saturates at 0xFFFF.
  - Cleared by reset and by each accepted start.
- When undefined: the port and the counter do not exist, and all other behaviour is identical.

Decomposition:
- Shared package ram_pkg holds:
  - D_WIDTH and A_WIDTH defaults.
  - The state enum (IDLE, READ, DRAIN) and its 2-bit encoding.
  - The constant RD_LATENCY=1.
- One natural sub-module: ram_skid_buf2, the 2-entry valid/ready FIFO with count output.
- The FSM, counters and credit logic stay in the top module.

Test Plan:
- Preload RAM[0..7]=16'h1000+i; start_addr=0, length=8, out_ready=1 → out_data 1000..1007 on consecutive cycles, out_last on the 1007 beat, done one cycle later.
- start_addr=30, length=4 → address_read sequence 30, 31, 0, 1; data matches RAM[30], RAM[31], RAM[0], RAM[1].
- length=6 with out_ready toggling 1,0,0,1,… → no beat lost or duplicated; out_data stable while stalled; with the macro defined, stall_count equals the number of stalled cycles.
- start with length=0; start pulsed while busy → no busy assertion and no done; the second start is ignored and the current burst completes unchanged.
- rst_n asserted low mid-burst after 3 of 8 beats → out_valid=0 and busy=0 immediately; a new burst (start_addr=4, length=2) afterwards returns RAM[4], RAM[5] only.
- length=32 (full depth) from start_addr=0 → all 32 words in order, address wraps back to 0, 32 beats, exactly one done pulse.

Source files
------------

// File: rtl/ram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_pkg                                                              |
// | Shared widths, read latency and burst-reader state encoding.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ram_pkg;

  localparam int unsigned RAM_D_WIDTH = 16;
  localparam int unsigned RAM_A_WIDTH = 5;
  localparam int unsigned RD_LATENCY  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/ram_skid_buf2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_skid_buf2                                                        |
// | Two-entry valid/ready FIFO; head entry drives the stream outputs.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ram_skid_buf2 #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_valid,
  output logic [1:0]   count
);

  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  // e0 is always the head; a pop from a full buffer shifts e1 forward.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          e0_d  = push_data;
          cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          e0_d = push_data;
        end else if (push) begin
          e1_d  = push_data;
          cnt_d = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          e0_d = e1_q;
          if (push) begin
            e1_d = push_data;
          end else begin
            cnt_d = 2'd1;
          end
        end
      end
    endcase
  end

  assign head_data  = e0_q;
  assign head_valid = (cnt_q != 2'd0);
  assign count      = cnt_q;

endmodule
`default_nettype wire

// File: rtl/ram_burst_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_burst_reader                                                     |
// | Turns a burst request into RAM reads and a valid/ready beat stream.  |
// | Optional: RAM_BURST_READER_STALL_CNT_EN adds a saturating stall_count.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ram_burst_reader
  import ram_pkg::*;
#(
  parameter int unsigned D_WIDTH = RAM_D_WIDTH,
  parameter int unsigned A_WIDTH = RAM_A_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [A_WIDTH-1:0] start_addr,
  input  logic [A_WIDTH:0]   length,
  output logic [A_WIDTH-1:0] address_read,
  input  logic [D_WIDTH-1:0] data_read,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               done
`ifdef RAM_BURST_READER_STALL_CNT_EN
  ,
  output logic [15:0]        stall_count
`endif
);

  // One beat waiting in the buffer plus one per cycle of read latency.
  localparam logic [2:0] CREDITS = 3'(1 + RD_LATENCY);

  rd_state_e            state_q, state_d;
  logic [A_WIDTH-1:0]   addr_cnt_q, addr_cnt_d;
  logic [A_WIDTH-1:0]   addr_hold_q, addr_hold_d;
  logic [A_WIDTH:0]     issue_cnt_q, issue_cnt_d;
  logic [A_WIDTH:0]     beat_cnt_q, beat_cnt_d;
  logic                 pending_q, pending_d;
  logic                 armed_q, armed_d;
  logic                 done_q, done_d;

  logic [1:0]           buf_count;
  logic                 pop;
  logic                 accept;
  logic                 issue;
  logic                 last_pop;
  logic [2:0]           inflight;

  ram_skid_buf2 #(
    .W (D_WIDTH)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (pending_q),
    .push_data  (data_read),
    .pop        (pop),
    .head_data  (out_data),
    .head_valid (out_valid),
    .count      (buf_count)
  );

  assign pop      = out_valid && out_ready;
  assign accept   = (state_q == ST_IDLE) && start && (length != '0);
  assign last_pop = pop && (beat_cnt_q == (A_WIDTH+1)'(1));
  assign inflight = {1'b0, buf_count} + {2'b00, pending_q} - {2'b00, pop};
  // The first READ cycle only arms the issue path, fixing the start-to-address delay.
  assign issue    = (state_q == ST_READ) && armed_q && (inflight < CREDITS);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_READ;
      ST_READ:  if (issue && (issue_cnt_q == (A_WIDTH+1)'(1))) state_d = ST_DRAIN;
      ST_DRAIN: if (last_pop) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt_q  <= '0;
      addr_hold_q <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      pending_q   <= 1'b0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      addr_cnt_q  <= addr_cnt_d;
      addr_hold_q <= addr_hold_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      pending_q   <= pending_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
    end
  end

  // Counter and credit updates
  always_comb begin
    addr_cnt_d  = addr_cnt_q;
    addr_hold_d = addr_hold_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    pending_d   = issue;
    armed_d     = (state_q == ST_READ);
    done_d      = (state_q == ST_DRAIN) && last_pop;
    if (accept) begin
      addr_cnt_d  = start_addr;
      issue_cnt_d = length;
      beat_cnt_d  = length;
    end
    if (issue) begin
      addr_cnt_d  = addr_cnt_q + A_WIDTH'(1);
      addr_hold_d = addr_cnt_q;
      issue_cnt_d = issue_cnt_q - (A_WIDTH+1)'(1);
    end
    if (pop) begin
      beat_cnt_d = beat_cnt_q - (A_WIDTH+1)'(1);
    end
  end

  // Outputs
  always_comb begin
    address_read = issue ? addr_cnt_q : addr_hold_q;
    busy         = (state_q != ST_IDLE);
    done         = done_q;
    out_last     = out_valid && (beat_cnt_q == (A_WIDTH+1)'(1));
  end

`ifdef RAM_BURST_READER_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (accept) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ram_burst_reader                                                  |
// | Directed vector table plus multi-cycle sequences for the reader.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ram_burst_reader;

  localparam int DEPTH = 32;
  localparam int NV    = 21;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  start_addr;
  logic [5:0]  length;
  logic [4:0]  address_read;
  logic [15:0] data_read;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef RAM_BURST_READER_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  logic [15:0] mem [0:DEPTH-1];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_seen;

  typedef struct {
    logic        start;
    logic [4:0]  saddr;
    logic [5:0]  len;
    logic        rdy;
    logic        busy;
    logic        valid;
    logic        last;
    logic        done;
    logic        chk_data;
    logic [15:0] data;
    logic        chk_addr;
    logic [4:0]  addr;
  } vec_t;

  vec_t vt [NV];

  always #5 clk = ~clk;

  // Registered-read RAM model sharing the reader clock.
  always @(posedge clk) data_read <= mem[address_read];

  ram_burst_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .start_addr   (start_addr),
    .length       (length),
    .address_read (address_read),
    .data_read    (data_read),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done)
`ifdef RAM_BURST_READER_STALL_CNT_EN
    ,
    .stall_count  (stall_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input bit st, input int sa, input int ln,
                              input bit bz, input bit v, input bit l, input bit d,
                              input int dat, input int ad);
    vec_t r;
    r.start    = st;
    r.saddr    = 5'(sa);
    r.len      = 6'(ln);
    r.rdy      = 1'b1;
    r.busy     = bz;
    r.valid    = v;
    r.last     = l;
    r.done     = d;
    r.chk_data = (dat >= 0);
    r.data     = 16'(dat);
    r.chk_addr = (ad >= 0);
    r.addr     = 5'(ad);
    return r;
  endfunction

  task automatic start_burst(input int sa, input int ln);
    start      = 1'b1;
    start_addr = 5'(sa);
    length     = 6'(ln);
    tick();
    start      = 1'b0;
  endtask

  // Scoreboards one burst: order, last flag, stability under stall, single done.
  task automatic collect(input int first, input int exp_n, input int mode,
                         input int inject_at, input string tag);
    int          n;
    int          dones;
    int          stalls;
    int          post;
    logic        prev_stall;
    logic [15:0] prev_data;
    logic [4:0]  a;
    n = 0; dones = 0; stalls = 0; post = -1; prev_stall = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 200 && post != 0; cyc++) begin
      out_ready = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      if (cyc == inject_at) begin
        start = 1'b1; start_addr = 5'd0; length = 6'd5;
      end else begin
        start = 1'b0;
      end
      if (prev_stall) begin
        check({tag, " hold valid"}, 32'(out_valid), 32'd1);
        check({tag, " hold data"}, 32'(out_data), 32'(prev_data));
      end
      if (done) dones++;
      if (out_valid && out_ready) begin
        a = 5'(first + n);
        check($sformatf("%s beat%0d data", tag, n), 32'(out_data), 32'(mem[a]));
        check($sformatf("%s beat%0d last", tag, n), 32'(out_last), 32'(n == exp_n - 1));
        n++;
      end
      prev_stall = out_valid && !out_ready;
      if (prev_stall) begin
        stalls++;
        prev_data = out_data;
      end
      if (post > 0) post--;
      else if (done) post = 2;
      tick();
    end
    start = 1'b0;
    check({tag, " beats"}, 32'(n), 32'(exp_n));
    check({tag, " done pulses"}, 32'(dones), 32'd1);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " idle valid"}, 32'(out_valid), 32'd0);
`ifdef RAM_BURST_READER_STALL_CNT_EN
    check({tag, " stall_count"}, 32'(stall_count), 32'(stalls));
`endif
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h1000 + 16'(i);
    rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; out_ready = 1'b1;

    // start, saddr, len | busy, valid, last, done, data(-1 skip), addr(-1 skip)
    vt[0]  = mk(1, 0, 8,  1, 0, 0, 0, -1,      -1);
    vt[1]  = mk(0, 0, 0,  1, 0, 0, 0, -1,       0);
    vt[2]  = mk(0, 0, 0,  1, 0, 0, 0, -1,       1);
    vt[3]  = mk(0, 0, 0,  1, 1, 0, 0, 'h1000,   2);
    vt[4]  = mk(0, 0, 0,  1, 1, 0, 0, 'h1001,   3);
    vt[5]  = mk(0, 0, 0,  1, 1, 0, 0, 'h1002,   4);
    vt[6]  = mk(0, 0, 0,  1, 1, 0, 0, 'h1003,   5);
    vt[7]  = mk(0, 0, 0,  1, 1, 0, 0, 'h1004,   6);
    vt[8]  = mk(0, 0, 0,  1, 1, 0, 0, 'h1005,   7);
    vt[9]  = mk(0, 0, 0,  1, 1, 0, 0, 'h1006,   7);
    vt[10] = mk(0, 0, 0,  1, 1, 1, 0, 'h1007,   7);
    vt[11] = mk(0, 0, 0,  0, 0, 0, 1, -1,       7);
    vt[12] = mk(1, 30, 4, 1, 0, 0, 0, -1,       7);
    vt[13] = mk(0, 0, 0,  1, 0, 0, 0, -1,      30);
    vt[14] = mk(0, 0, 0,  1, 0, 0, 0, -1,      31);
    vt[15] = mk(0, 0, 0,  1, 1, 0, 0, 'h101E,   0);
    vt[16] = mk(0, 0, 0,  1, 1, 0, 0, 'h101F,   1);
    vt[17] = mk(0, 0, 0,  1, 1, 0, 0, 'h1000,   1);
    vt[18] = mk(0, 0, 0,  1, 1, 1, 0, 'h1001,   1);
    vt[19] = mk(0, 0, 0,  0, 0, 0, 1, -1,       1);
    vt[20] = mk(0, 0, 0,  0, 0, 0, 0, -1,       1);

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset valid", 32'(out_valid), 32'd0);
    check("reset last", 32'(out_last), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset addr", 32'(address_read), 32'd0);
`ifdef RAM_BURST_READER_STALL_CNT_EN
    check("reset stall_count", 32'(stall_count), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < NV; k++) begin
      start = vt[k].start; start_addr = vt[k].saddr; length = vt[k].len; out_ready = vt[k].rdy;
      tick();
      check($sformatf("vec%0d busy", k), 32'(busy), 32'(vt[k].busy));
      check($sformatf("vec%0d valid", k), 32'(out_valid), 32'(vt[k].valid));
      check($sformatf("vec%0d last", k), 32'(out_last), 32'(vt[k].last));
      check($sformatf("vec%0d done", k), 32'(done), 32'(vt[k].done));
      if (vt[k].chk_data) check($sformatf("vec%0d data", k), 32'(out_data), 32'(vt[k].data));
      if (vt[k].chk_addr) check($sformatf("vec%0d addr", k), 32'(address_read), 32'(vt[k].addr));
    end
    start = 1'b0;
    tick();

    // Ready pattern 1,0,0,1 repeating
    start_burst(8, 6);
    collect(8, 6, 1, -1, "stall");

    // Zero-length request must be ignored entirely
    start_burst(3, 0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("len0 busy c%0d", i), 32'(busy), 32'd0);
      check($sformatf("len0 done c%0d", i), 32'(done), 32'd0);
      tick();
    end

    // Second start while busy must not disturb the running burst
    start_burst(16, 3);
    collect(16, 3, 0, 2, "busy-start");

    // Asynchronous reset after three accepted beats
    start_burst(0, 8);
    out_ready = 1'b1;
    n_seen = 0;
    for (int c = 0; c < 40 && n_seen < 3; c++) begin
      if (out_valid) n_seen++;
      tick();
    end
    check("pre-reset beats", 32'(n_seen), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-reset valid", 32'(out_valid), 32'd0);
    check("mid-reset busy", 32'(busy), 32'd0);
    check("mid-reset done", 32'(done), 32'd0);
    check("mid-reset last", 32'(out_last), 32'd0);
    check("mid-reset addr", 32'(address_read), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    start_burst(4, 2);
    collect(4, 2, 0, -1, "post-reset");

    // Full-depth burst
    start_burst(0, 32);
    collect(0, 32, 0, -1, "full");
    check("full addr hold", 32'(address_read), 32'd31);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
